// File: rtl/ram_req_ctrl_if.sv
// Request/response and RAM-side signal bundle for the RAM requester controller.
// Latency: none (wires only).
// Backpressure: req_ready gates requests; rsp_valid is never back-pressured.
interface ram_req_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // requester -> controller
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wdata;

    // controller -> requester
    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;

    // controller <-> RAM
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [ADDR_W-1:0] ram_w_addr;
    logic [DATA_W-1:0] ram_w_data;
    logic [DATA_W-1:0] ram_r_data;

    // controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, ram_r_data,
        output req_ready, rsp_valid, rsp_we, rsp_rdata,
               ram_wren, ram_r_addr, ram_w_addr, ram_w_data
    );

    // requester + RAM side
    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, ram_r_data,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata,
               ram_wren, ram_r_addr, ram_w_addr, ram_w_data
    );
endinterface

// File: rtl/ram_req_ctrl.sv
// Word read/write controller for a 1-cycle-read dual-port RAM; byte-enable stores done by read-modify-write.
// Latency: read / full write / empty-be write respond 2 edges after acceptance, partial write 3 edges.
// Backpressure: req_ready high only in IDLE; responses are single-cycle pulses with no back-pressure.
module ram_req_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_req_ctrl_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        RMW_RD = 2'd2,
        WR     = 2'd3
    } state_t;

    state_t            state;

    // request captured at acceptance
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;

    // registered outputs
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_we_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              ram_wren_q;
    logic [ADDR_W-1:0] ram_w_addr_q;
    logic [DATA_W-1:0] ram_w_data_q;

    logic              accept;

    // Byte-wise merge: enabled bytes from the new data, the rest from the old word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] new_word,
        input logic [DATA_W-1:0] old_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] m;
        m = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return m;
    endfunction

    assign accept = bus.req_valid && req_ready_q;

    // In IDLE the RAM sees the incoming address directly so its registered read
    // address captures it on the acceptance edge; afterwards it sees the latched one.
    assign bus.ram_r_addr = (state == IDLE) ? bus.req_addr : addr_q;

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_we     = rsp_we_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.ram_w_addr = ram_w_addr_q;
    assign bus.ram_w_data = ram_w_data_q;

    // Main controller: state sequencing and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_we_q     <= 1'b0;
            rsp_rdata_q  <= '0;
            ram_wren_q   <= 1'b0;
            ram_w_addr_q <= '0;
            ram_w_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (accept) begin
                        addr_q      <= bus.req_addr;
                        we_q        <= bus.req_we;
                        be_q        <= bus.req_be;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (!bus.req_we) begin
                            state <= RD;
                        end else if (bus.req_be == '1) begin
                            // whole word: write straight away, no read needed
                            state        <= WR;
                            ram_wren_q   <= 1'b1;
                            ram_w_addr_q <= bus.req_addr;
                            ram_w_data_q <= bus.req_wdata;
                        end else if (bus.req_be == '0) begin
                            // nothing to store: just produce the ack
                            state      <= WR;
                            ram_wren_q <= 1'b0;
                        end else begin
                            state <= RMW_RD;
                        end
                    end else begin
                        // also raises ready on the first edge after reset release
                        req_ready_q <= 1'b1;
                    end
                end

                RD: begin
                    rsp_rdata_q <= bus.ram_r_data;
                    rsp_valid_q <= 1'b1;
                    rsp_we_q    <= we_q;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end

                RMW_RD: begin
                    // old word is on ram_r_data now; stage the merged word for the write cycle
                    ram_w_data_q <= merge_bytes(wdata_q, bus.ram_r_data, be_q);
                    ram_w_addr_q <= addr_q;
                    ram_wren_q   <= 1'b1;
                    state        <= WR;
                end

                WR: begin
                    // RAM commits on this edge, so a following read sees the new word
                    ram_wren_q  <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_we_q    <= we_q;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state       <= IDLE;
                    ram_wren_q  <= 1'b0;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready is only ever offered while idle.
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        req_ready_q |-> (state == IDLE));

    // The RAM write strobe is only driven from the write state.
    a_wren_wr: assert property (@(posedge clk) disable iff (!rst_n)
        ram_wren_q |-> (state == WR));

    // A response is never stretched beyond one cycle.
    a_rsp_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_q |=> !rsp_valid_q);

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl with a behavioural RAM and a word-level reference model.
// Latency: expectations derived from operation type (2 edges, 3 for partial byte-enable writes).
// Backpressure: requests held until ready; every response pulse is counted against the model.
module tb_ram_req_ctrl;
    logic clk;
    logic rst_n;

    ram_req_ctrl_if #(.ADDR_W(5), .DATA_W(32)) ifc ();

    ram_req_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read address, synchronous write, no reset.
    logic [31:0] mem [0:31];
    logic [4:0]  r_addr_q;
    always @(posedge clk) begin
        if (ifc.ram_wren) mem[ifc.ram_w_addr] <= ifc.ram_w_data;
        r_addr_q <= ifc.ram_r_addr;
    end
    assign ifc.ram_r_data = mem[r_addr_q];

    // Reference model state
    logic [31:0] ref_mem [0:31];
    logic [31:0] last_rd;
    int          exp_rsp;
    int          exp_wr;

    // Counters
    int n_chk;
    int n_fail;
    int cyc;
    int acc_cyc;
    int rsp_pulses;
    int wren_cycles;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.rsp_valid) rsp_pulses <= rsp_pulses + 1;
            if (ifc.ram_wren)  wren_cycles <= wren_cycles + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Word-level store model: build a byte mask from the enables and blend.
    function automatic logic [31:0] ref_store(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    // Issue one request, follow it to its response and check everything about it.
    // Called at #1 after a rising edge; returns at #1 after the response edge.
    task automatic send(input bit we, input logic [4:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input bit hold, output int lat);
        logic [31:0] exp_w;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_wc;
        int          wr_seen;
        int          k;
        bit          acc;
        bit          done;

        exp_w   = ref_store(ref_mem[a], wd, be);
        exp_rd  = we ? last_rd : ref_mem[a];
        exp_lat = (we && be != 4'h0 && be != 4'hF) ? 3 : 2;
        exp_wc  = (we && be != 4'h0) ? 1 : 0;

        ifc.req_valid = 1'b1;
        ifc.req_we    = we;
        ifc.req_addr  = a;
        ifc.req_be    = be;
        ifc.req_wdata = wd;

        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (ifc.req_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        lat = 0;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            ifc.req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        if (!hold) ifc.req_valid = 1'b0;

        wr_seen = 0;
        k       = 0;
        done    = 1'b0;
        while (!done && k < 10) begin
            if (ifc.ram_wren) begin
                wr_seen++;
                chk("ram_w_addr", 32'(ifc.ram_w_addr), 32'(a));
                chk("ram_w_data", ifc.ram_w_data, exp_w);
            end
            if (ifc.rsp_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        if (!done) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        lat = k + 1;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_we", 32'(ifc.rsp_we), 32'(we));
        chk("rsp_rdata", ifc.rsp_rdata, exp_rd);
        chk("wren_cycles", 32'(wr_seen), 32'(exp_wc));

        if (we) ref_mem[a] = exp_w;
        else    last_rd    = ref_mem[a];
        exp_rsp++;
        exp_wr += exp_wc;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          prev_acc;
        int          prev_lat;
        bit          we;
        logic [4:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          hold;

        n_chk = 0; n_fail = 0;
        exp_rsp = 0; exp_wr = 0; last_rd = 32'h0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

        // ---- reset state ----
        rst_n         = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_we    = 1'b0;
        ifc.req_addr  = 5'd9;
        ifc.req_be    = 4'h0;
        ifc.req_wdata = 32'h0;
        idle_cycles(3);
        chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("rst_rsp_we", 32'(ifc.rsp_we), 32'd0);
        chk("rst_rsp_rdata", ifc.rsp_rdata, 32'h0);
        chk("rst_ram_wren", 32'(ifc.ram_wren), 32'd0);
        chk("rst_ram_w_addr", 32'(ifc.ram_w_addr), 32'd0);
        chk("rst_ram_w_data", ifc.ram_w_data, 32'h0);
        chk("rst_ram_r_addr", 32'(ifc.ram_r_addr), 32'd9);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 32'(ifc.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ready_after_edge", 32'(ifc.req_ready), 32'd1);

        // ---- full write then read ----
        send(1'b1, 5'd3, 4'hF, 32'hDEADBEEF, 1'b0, lat);
        send(1'b0, 5'd3, 4'h0, 32'h0, 1'b0, lat);

        // ---- partial write by read-modify-write ----
        send(1'b1, 5'd7, 4'hF, 32'h11223344, 1'b0, lat);
        send(1'b1, 5'd7, 4'h2, 32'hAABBCCDD, 1'b0, lat);
        send(1'b0, 5'd7, 4'h0, 32'h0, 1'b0, lat);
        chk("partial_merge_value", last_rd, 32'h1122CC44);

        // ---- empty byte-enable write ----
        send(1'b1, 5'd7, 4'h0, 32'h55555555, 1'b0, lat);
        send(1'b0, 5'd7, 4'h0, 32'h0, 1'b0, lat);
        chk("be0_unchanged", last_rd, 32'h1122CC44);

        // ---- back-to-back with req_valid held, addr 0 ----
        send(1'b1, 5'd0, 4'hF, 32'd1, 1'b1, lat);
        prev_acc = acc_cyc; prev_lat = lat;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: send(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, lat);
                1: send(1'b1, 5'd0, 4'hF, 32'd2, 1'b1, lat);
                2: send(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, lat);
                3: send(1'b1, 5'd0, 4'h1, 32'd3, 1'b1, lat);
                default: send(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, lat);
            endcase
            chk("b2b_spacing", 32'(acc_cyc - prev_acc), 32'(prev_lat));
            prev_acc = acc_cyc; prev_lat = lat;
        end
        ifc.req_valid = 1'b0;
        chk("b2b_last_read", last_rd, 32'd3);
        idle_cycles(2);

        // ---- reset during RMW_RD of a partial write to addr 5 ----
        send(1'b1, 5'd5, 4'hF, 32'h0, 1'b0, lat);
        ifc.req_valid = 1'b1;
        ifc.req_we    = 1'b1;
        ifc.req_addr  = 5'd5;
        ifc.req_be    = 4'h3;
        ifc.req_wdata = 32'hFFFFFFFF;
        chk("mid_ready_pre", 32'(ifc.req_ready), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(ifc.req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("mid_rst_rsp_rdata", ifc.rsp_rdata, 32'h0);
        chk("mid_rst_ram_wren", 32'(ifc.ram_wren), 32'd0);
        chk("mid_rst_ram_w_data", ifc.ram_w_data, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("hold_rst_req_ready", 32'(ifc.req_ready), 32'd0);
            chk("hold_rst_ram_wren", 32'(ifc.ram_wren), 32'd0);
            chk("hold_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        end
        ifc.req_valid = 1'b0;
        last_rd       = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel2_ready_before_edge", 32'(ifc.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel2_ready_after_edge", 32'(ifc.req_ready), 32'd1);
        send(1'b0, 5'd5, 4'h0, 32'h0, 1'b0, lat);
        chk("mid_rst_no_write", last_rd, 32'h0);

        // ---- randomized traffic ----
        for (int i = 0; i < 32; i++)
            send(1'b1, 5'(i), 4'hF, $urandom, 1'b0, lat);
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       be = 4'h0;
                1:       be = 4'hF;
                default: be = 4'($urandom_range(0, 15));
            endcase
            wd   = $urandom;
            hold = 1'($urandom_range(0, 1));
            send(we, a, be, wd, hold, lat);
            if (!hold) idle_cycles($urandom_range(0, 2));
        end
        ifc.req_valid = 1'b0;
        idle_cycles(3);

        chk("total_rsp_pulses", 32'(rsp_pulses), 32'(exp_rsp));
        chk("total_wren_cycles", 32'(wren_cycles), 32'(exp_wr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
